// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word read at a time, holds the returned
// instruction for decode, and handles stall, redirect and in-flight flushes.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] abandon_addr_q, abandon_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;

  logic        consume;
  logic        issue;
  logic [31:0] target_pc;

  assign consume   = valid_q & ~stall;
  assign issue     = (~valid_q | ~stall) & ~redirect;
  assign target_pc = redirect_pc & ~32'd3;

  // NOTE: non-blocking assignments only in clocked blocks, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      abandon_addr_q <= 32'd0;
      instr_q        <= 32'd0;
      instr_pc_q     <= 32'd0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      abandon_addr_q <= abandon_addr_d;
      instr_q        <= instr_d;
      instr_pc_q     <= instr_pc_d;
      valid_q        <= valid_d;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    abandon_addr_d = abandon_addr_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    valid_d        = valid_q;

    if (consume) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A stray ack with no request outstanding is ignored here.
        if (redirect) begin
          pc_d    = target_pc;
          valid_d = 1'b0;
        end else if (issue) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (redirect) begin
          pc_d    = target_pc;
          valid_d = 1'b0;
          if (imem_ack) begin
            state_d = IDLE;
          end else begin
            state_d        = DISCARD;
            abandon_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = IDLE;
        end
      end
      DISCARD: begin
        // The outstanding address stays on the bus until its data is dropped.
        if (redirect) begin
          pc_d    = target_pc;
          valid_d = 1'b0;
        end
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q != IDLE);
    imem_addr = (state_q == DISCARD) ? abandon_addr_q : pc_q;
  end

  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the corner cases, then a
// randomized run against a transaction-level model of fetch behaviour.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_valid;
  } vec_t;

  // Reference model: a single outstanding-request record plus the held instruction.
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_paddr;
  logic        m_drop;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic rdr,
                       input logic [31:0] rpc, input logic ack, input logic [31:0] rdata);
    reset       = rst;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_rdata  = rdata;
    @(posedge clock);
    #1;
  endtask

  task automatic model_step(input logic rst, input logic stl, input logic rdr,
                            input logic [31:0] rpc, input logic ack, input logic [31:0] rdata);
    logic consumed;
    logic loaded;
    if (rst) begin
      m_pc = 32'h0; m_pend = 1'b0; m_paddr = 32'h0; m_drop = 1'b0;
      m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0;
      return;
    end
    consumed = m_valid && !stl;
    loaded   = 1'b0;
    if (m_pend) begin
      if (ack) begin
        m_pend = 1'b0;
        if (!m_drop && !rdr) begin
          m_instr = rdata;
          m_ipc   = m_paddr;
          m_pc    = m_paddr + 32'd4;
          loaded  = 1'b1;
        end
      end
      if (rdr) begin
        m_drop  = 1'b1;
        m_pc    = {rpc[31:2], 2'b00};
        m_valid = 1'b0;
      end
    end else if (rdr) begin
      m_pc    = {rpc[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (!m_valid || !stl) begin
      m_pend  = 1'b1;
      m_paddr = m_pc;
      m_drop  = 1'b0;
    end
    if (loaded) m_valid = 1'b1;
    else if (consumed) m_valid = 1'b0;
  endtask

  vec_t vecs[26];

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    //         rst   stl   rdr   rpc            ack   rdata          req   addr           instr          ipc            valid
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         32'h0,         32'h0,         1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0022_5020, 1'b0, 32'h4,         32'h0022_5020, 32'h0,         1'b1};
    for (int i = 3; i <= 7; i++)
      vecs[i] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h4,         32'h0022_5020, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         32'h0022_5020, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0,         1'b1, 32'h4,         32'h0022_5020, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         32'h0022_5020, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         32'h0022_5020, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h100,       32'h0022_5020, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100,       32'h0022_5020, 32'h0,         1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h1234_5678, 1'b0, 32'hFFFF_FFFC, 32'h0022_5020, 32'h0,         1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0022_5020, 32'h0,         1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8C22_0004, 1'b0, 32'h0,         32'h8C22_0004, 32'hFFFF_FFFC, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         32'h8C22_0004, 32'hFFFF_FFFC, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0,         1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hAAAA_5555, 1'b1, 32'h0,         32'h0,         32'h0,         1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_1111, 1'b0, 32'h4,         32'h0000_1111, 32'h0,         1'b1};
    vecs[21] = '{1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 32'h40,        32'h0000_1111, 32'h0,         1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40,        32'h0000_1111, 32'h0,         1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0,         1'b1, 32'h40,        32'h0000_1111, 32'h0,         1'b0};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 32'h0000_00C1, 1'b0, 32'h0,         1'b1, 32'h40,        32'h0000_1111, 32'h0,         1'b0};
    vecs[25] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h5555_AAAA, 1'b0, 32'hC0,        32'h0000_1111, 32'h0,         1'b0};

    @(negedge clock);
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      check("tbl_req",   i, {31'd0, imem_req},    {31'd0, vecs[i].e_req});
      check("tbl_addr",  i, imem_addr,            vecs[i].e_addr);
      check("tbl_instr", i, instruction,          vecs[i].e_instr);
      check("tbl_ipc",   i, instr_pc,             vecs[i].e_ipc);
      check("tbl_valid", i, {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
    end

    // Randomized phase: start from reset so model and DUT agree.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    model_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      logic        r_rst, r_stl, r_rdr, r_ack;
      logic [31:0] r_rpc, r_rdata;
      r_rst   = ($urandom_range(0, 99) == 0);
      r_stl   = ($urandom_range(0, 2) == 0);
      r_rdr   = ($urandom_range(0, 9) == 0);
      r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom;
      r_ack   = imem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      r_rdata = $urandom;
      drive(r_rst, r_stl, r_rdr, r_rpc, r_ack, r_rdata);
      model_step(r_rst, r_stl, r_rdr, r_rpc, r_ack, r_rdata);
      check("rnd_req",   c, {31'd0, imem_req},    {31'd0, m_pend});
      check("rnd_addr",  c, imem_addr,            m_pend ? m_paddr : m_pc);
      check("rnd_valid", c, {31'd0, instr_valid}, {31'd0, m_valid});
      check("rnd_instr", c, instruction,          m_instr);
      check("rnd_ipc",   c, instr_pc,             m_ipc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset (bits [1:0] SHALL be 0).
REQ-002 Port: clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: imem_req  output  1  instruction-memory read request.
REQ-005 Port: imem_addr  output  32  byte address of the requested word.
REQ-006 Port: imem_ack  input  1  memory returns data this cycle.
REQ-007 Port: imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 Port: stall  input  1  downstream decode/control cannot accept the held instruction.
REQ-009 Port: redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 Port: redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored (treated as 00).
REQ-011 Port: instruction  output  32  registered instruction word driving the control unit (opcode [31:26], funct [5:0]).
REQ-012 Port: instr_pc  output  32  address of the held instruction.
REQ-013 Port: instr_valid  output  1  instruction/instr_pc hold a live instruction.

Function
REQ-014 States SHALL be IDLE, BUSY (request outstanding) and DISCARD (request outstanding, its data to be dropped).
REQ-015 Consume event SHALL be defined as instr_valid=1 and stall=0 at a clock edge; it SHALL clear instr_valid on that edge unless new data loads on the same edge.
REQ-016 Issue condition SHALL be (instr_valid=0 or stall=0) and redirect=0.
REQ-017 IDLE: imem_req=0; on the issue condition, the block SHALL go to BUSY and hold pc unchanged.
REQ-018 BUSY and DISCARD: imem_req=1, and imem_addr SHALL be held constant until imem_ack.
REQ-019 imem_addr SHALL equal pc in IDLE and BUSY, and the abandoned address in DISCARD.
REQ-020 BUSY with imem_ack=1 and redirect=0: the block SHALL set instruction<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 and go to IDLE.
REQ-021 Throughput: minimum two cycles per fetch; load-to-use latency SHALL be one edge after ack.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Redirect in IDLE: the block SHALL set pc<=redirect_pc, instr_valid<=0, and stay in IDLE.
REQ-024 Redirect in BUSY without ack: the block SHALL set pc<=redirect_pc, instr_valid<=0, and go to DISCARD.
REQ-025 Redirect in BUSY with ack on the same edge: returned data SHALL be dropped; pc<=redirect_pc, instr_valid<=0, go to IDLE.
REQ-026 DISCARD with imem_ack: data SHALL be dropped and the block SHALL go to IDLE; a redirect in DISCARD SHALL update pc again and keep instr_valid=0.
REQ-027 Redirect SHALL take priority over stall and over consume; the held instruction SHALL be flushed even if stalled.
REQ-028 imem_ack in IDLE SHALL be ignored, with no state change.
REQ-029 While instr_valid=1 and stall=1, instruction/instr_pc SHALL be held stable.

Reset
REQ-030 reset=1 at an edge SHALL force state=IDLE, pc=RESET_PC, instr_valid=0, instruction=0, instr_pc=0; imem_req SHALL be 0 from the next cycle.
REQ-031 Reset SHALL override redirect, ack and stall.
REQ-032 Reset mid-BUSY SHALL abandon the request; a late ack after reset SHALL be ignored per REQ-028.

Verification
REQ-033 Reset release, memory acks 1 cycle after req with 32'h0022_5020 -> imem_addr=0, instruction=32'h0022_5020, instr_pc=0, instr_valid=1; next imem_addr=4.
REQ-034 stall=1 held 5 cycles with instr_valid=1 -> imem_req=0, instruction unchanged; stall=0 -> fetch of next pc issues on that edge.
REQ-035 redirect=1, redirect_pc=32'h0000_0103 during BUSY, ack 3 cycles later with 32'hDEAD_BEEF -> DEAD_BEEF never appears on instruction; next imem_addr=32'h0000_0100.
REQ-036 redirect and imem_ack on the same edge -> data dropped, instr_valid=0, pc=redirect_pc.
REQ-037 pc=32'hFFFF_FFFC fetch acked -> instr_pc=32'hFFFF_FFFC, next imem_addr=0.
REQ-038 reset asserted during BUSY, stray ack the following cycle -> instr_valid stays 0, imem_addr=RESET_PC on next issue.
